// File: rtl/mem_bus_master.sv
// mem_bus_master: CPU-side initiator for the LC-3 memory/MMIO bus.
// Accepts one load/store request, presents it on MAR_OUT/MDR_OUT/RW, and runs a
// 4-phase handshake (MIO_EN up, wait R up, MIO_EN down, wait R down) before
// pulsing done. Optional watchdog: define MEM_TIMEOUT_EN to abort a stalled
// handshake after TIMEOUT_CYCLES cycles, reported by err together with done.
module mem_bus_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] MAR_OUT,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic              MIO_EN,
  output logic              RW,
  input  logic              R,
  input  logic [DATA_W-1:0] MEM_OUT
);

  // The watchdog counter is 8 bits wide, so the abort point must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("mem_bus_master: TIMEOUT_CYCLES must be in 2..256");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  state_t            state, state_nxt;
  logic              mio_en_nxt, rw_nxt, done_nxt;
  logic [ADDR_W-1:0] mar_nxt;
  logic [DATA_W-1:0] mdr_nxt, rdata_nxt;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_nxt;
  logic       stalled;
`else
  assign err = 1'b0;
`endif

  // Next-state and next-output logic; every registered output defaults to hold.
  always_comb begin
    state_nxt  = state;
    mio_en_nxt = MIO_EN;
    rw_nxt     = RW;
    mar_nxt    = MAR_OUT;
    mdr_nxt    = MDR_OUT;
    rdata_nxt  = rdata;
    done_nxt   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    err_nxt      = 1'b0;
    wait_cnt_nxt = wait_cnt;
    stalled      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          mar_nxt   = req_addr;
          mdr_nxt   = req_wdata;
          rw_nxt    = req_we;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        // A responder may still be showing ready from the previous cycle.
        if (!R) begin
          mio_en_nxt = 1'b1;
          state_nxt  = ACCESS;
`ifdef MEM_TIMEOUT_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      ACCESS: begin
        mio_en_nxt = 1'b1;
        if (R) begin
          mio_en_nxt = 1'b0;
          if (!RW) rdata_nxt = MEM_OUT;
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        mio_en_nxt = 1'b0;
        if (!R) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
`ifdef MEM_TIMEOUT_EN
    // Watchdog: runs through ACCESS and RELEASE, fires only when the current
    // handshake step is not being taken this cycle.
    if (state == ACCESS || state == RELEASE) begin
      wait_cnt_nxt = wait_cnt + 8'd1;
      stalled      = (state == ACCESS) ? !R : R;
      if (stalled && wait_cnt == WAIT_LAST) begin
        mio_en_nxt = 1'b0;
        done_nxt   = 1'b1;
        err_nxt    = 1'b1;
        state_nxt  = IDLE;
      end
    end
`endif
  end

  // State and output registers; reset drops the bus cycle and discards the access.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      MIO_EN  <= 1'b0;
      RW      <= 1'b0;
      MAR_OUT <= '0;
      MDR_OUT <= '0;
      rdata   <= '0;
`ifdef MEM_TIMEOUT_EN
      err      <= 1'b0;
      wait_cnt <= 8'd0;
`endif
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
      MIO_EN  <= mio_en_nxt;
      RW      <= rw_nxt;
      MAR_OUT <= mar_nxt;
      MDR_OUT <= mdr_nxt;
      rdata   <= rdata_nxt;
`ifdef MEM_TIMEOUT_EN
      err      <= err_nxt;
      wait_cnt <= wait_cnt_nxt;
`endif
    end
  end

endmodule
